// File: rtl/sram_like_mem_slave.sv
// sram_like_mem_slave: SRAM-like memory responder with byte-lane writes,
// a fixed response latency and a 2-deep in-order outstanding queue.
module sram_like_mem_slave #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_LATENCY = 3,
    parameter int QDEPTH       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok,
    input  logic        addr_stall,
    output logic [1:0]  outstanding
);
    localparam int         AW  = ADDR_WIDTH + 2;
    localparam logic [1:0] QD  = 2'(QDEPTH);
    localparam logic [3:0] LAT = 4'(DATA_LATENCY);

    logic            q_wr_q    [2];
    logic [1:0]      q_size_q  [2];
    logic [AW-1:0]   q_addr_q  [2];
    logic [31:0]     q_wdata_q [2];
    logic [31:0]     mem [2**ADDR_WIDTH];
    logic [1:0]      count_q, count_d;
    logic [3:0]      head_cnt_q, head_cnt_d;
    logic            rd_ptr_q, wr_ptr_q;
    logic            push, pop, head_valid, h_wr;
    logic [1:0]      h_size;
    logic [AW-1:0]   h_addr;
    logic [31:0]     h_wdata;
    logic [3:0]      mask;
    logic            unused_addr;

    assign unused_addr = ^addr[31:AW];
    assign head_valid  = count_q != 2'd0;
    assign addr_ok     = rst & req & ~addr_stall & (count_q < QD);
    assign push        = req & addr_ok;
    assign data_ok     = head_valid & (head_cnt_q == LAT);
    assign pop         = data_ok;
    assign outstanding = count_q;

    assign h_wr    = q_wr_q[rd_ptr_q];
    assign h_size  = q_size_q[rd_ptr_q];
    assign h_addr  = q_addr_q[rd_ptr_q];
    assign h_wdata = q_wdata_q[rd_ptr_q];

    // Halfword lanes follow addr[1] only, so a misaligned halfword lands on its aligned pair.
    assign mask  = h_size[1] ? 4'b1111 : h_size[0] ? (h_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << h_addr[1:0];
    assign rdata = (data_ok & ~h_wr) ? mem[h_addr[AW-1:2]] : 32'd0;

    assign count_d = count_q + {1'b0, push} - {1'b0, pop};
    // A fresh head (push into empty, promotion, or push+pop at count 1) restarts its latency at 1.
    assign head_cnt_d = ((push & ~head_valid) | (pop & (count_q[1] | push))) ? 4'd1 :
                        pop ? 4'd0 :
                        (head_valid & (head_cnt_q < LAT)) ? head_cnt_q + 4'd1 : head_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= 2'd0;
            head_cnt_q <= 4'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            head_cnt_q <= head_cnt_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_wr_q[wr_ptr_q]    <= wr;
            q_size_q[wr_ptr_q]  <= size;
            q_addr_q[wr_ptr_q]  <= addr[AW-1:0];
            q_wdata_q[wr_ptr_q] <= wdata;
        end
        if (pop & h_wr)
            for (int b = 0; b < 4; b++)
                if (mask[b]) mem[h_addr[AW-1:2]][8*b +: 8] <= h_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_sram_like_mem_slave.sv
// tb_sram_like_mem_slave: directed checks of the memory responder at latency 3 (u_dut)
// and latency 1 (u_dut1).
module tb_sram_like_mem_slave;
    logic        clk, rst;
    logic        req, wr, addr_stall;
    logic [1:0]  size, outstanding;
    logic [31:0] addr, wdata, rdata;
    logic        addr_ok, data_ok;
    logic        req1, wr1, addr_ok1, data_ok1;
    logic [1:0]  size1, outstanding1;
    logic [31:0] addr1, wdata1, rdata1;
    int          n_chk = 0, n_pass = 0;
    int          k, rk;

    logic [31:0] wv [4]     = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    int          qf_aok [13] = '{1,1,0,0,1,0,0,1,0,0,0,0,0};
    int          qf_dok [13] = '{0,0,0,1,0,0,1,0,0,1,0,0,1};
    int          qf_out [13] = '{0,1,2,2,1,2,2,1,2,2,1,1,1};
    logic        l1_req  [6] = '{1,1,1,1,0,0};
    logic        l1_wr   [6] = '{1,1,0,0,0,0};
    logic [31:0] l1_addr [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h0};
    logic [31:0] l1_wd   [6] = '{32'hCAFE0000, 32'h0000F00D, 32'h0, 32'h0, 32'h0, 32'h0};
    int          l1_aok  [6] = '{1,1,1,1,0,0};
    int          l1_dok  [6] = '{0,1,1,1,1,0};
    int          l1_out  [6] = '{0,1,1,1,1,0};
    logic [31:0] l1_rd   [6] = '{32'h0, 32'h0, 32'h0, 32'hCAFE0000, 32'h0000F00D, 32'h0};

    sram_like_mem_slave #(.ADDR_WIDTH(10), .DATA_LATENCY(3), .QDEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok), .addr_stall(addr_stall),
        .outstanding(outstanding)
    );

    sram_like_mem_slave #(.ADDR_WIDTH(10), .DATA_LATENCY(1), .QDEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .addr_ok(addr_ok1), .data_ok(data_ok1), .addr_stall(1'b0),
        .outstanding(outstanding1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete single transaction at latency 3: accept now, response on the third cycle after.
    task automatic xfer(input string tag, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] er);
        @(negedge clk);
        req = 1'b1; wr = w; size = s; addr = a; wdata = d; addr_stall = 1'b0;
        #1;
        chk({tag, ".aok"}, 32'(addr_ok), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            req = 1'b0;
            #1;
            chk($sformatf("%s.dok%0d", tag, i), 32'(data_ok), (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("%s.rd%0d", tag, i), rdata, (i == 3) ? er : 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0; req = 1'b1; wr = 1'b0; size = 2'b10; addr = '0; wdata = '0; addr_stall = 1'b0;
        req1 = 1'b0; wr1 = 1'b0; size1 = 2'b10; addr1 = '0; wdata1 = '0;
        @(negedge clk); #1;
        chk("rst.aok", 32'(addr_ok), 32'd0);
        chk("rst.dok", 32'(data_ok), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.out", 32'(outstanding), 32'd0);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;

        xfer("sw10", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0);
        xfer("lw10", 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF);
        xfer("sb11", 1'b1, 2'b00, 32'h11, 32'h0000AA00, 32'h0);
        xfer("lw_sb", 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADAAEF);
        xfer("sh12", 1'b1, 2'b01, 32'h12, 32'h12340000, 32'h0);
        xfer("lw_sh", 1'b0, 2'b10, 32'h10, 32'h0, 32'h1234AAEF);
        xfer("sh13", 1'b1, 2'b01, 32'h13, 32'h5678FFFF, 32'h0);
        xfer("lw_mis", 1'b0, 2'b10, 32'h10, 32'h0, 32'h5678AAEF);
        xfer("sw0", 1'b1, 2'b11, 32'h0, wv[0], 32'h0);
        xfer("sw4", 1'b1, 2'b10, 32'h4, wv[1], 32'h0);
        xfer("sw8", 1'b1, 2'b10, 32'h8, wv[2], 32'h0);
        xfer("swc", 1'b1, 2'b10, 32'hC, wv[3], 32'h0);

        k = 0; rk = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            req = (k < 4); wr = 1'b0; size = 2'b10; addr = 32'(k * 4);
            #1;
            chk($sformatf("qf.aok%0d", c), 32'(addr_ok), 32'(qf_aok[c]));
            chk($sformatf("qf.dok%0d", c), 32'(data_ok), 32'(qf_dok[c]));
            chk($sformatf("qf.out%0d", c), 32'(outstanding), 32'(qf_out[c]));
            chk($sformatf("qf.rd%0d", c), rdata, (qf_dok[c] != 0) ? wv[rk] : 32'd0);
            if (qf_aok[c] != 0) k++;
            if (qf_dok[c] != 0) rk++;
        end
        @(negedge clk); req = 1'b0; #1;
        chk("qf.drain", 32'(outstanding), 32'd0);

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req = 1'b1; wr = 1'b0; addr = 32'h4; addr_stall = 1'b1;
            #1;
            chk($sformatf("stall.aok%0d", c), 32'(addr_ok), 32'd0);
            chk($sformatf("stall.out%0d", c), 32'(outstanding), 32'd0);
        end
        xfer("unstall", 1'b0, 2'b10, 32'h4, 32'h0, wv[1]);

        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hAAAAAAAA; #1;
        chk("mr.aok0", 32'(addr_ok), 32'd1);
        @(negedge clk);
        addr = 32'h4; wdata = 32'hBBBBBBBB; #1;
        chk("mr.aok1", 32'(addr_ok), 32'd1);
        @(negedge clk);
        req = 1'b0; #1;
        chk("mr.out2", 32'(outstanding), 32'd2);
        @(negedge clk); #1;
        chk("mr.dok_pre", 32'(data_ok), 32'd1);
        rst = 1'b0; #1;
        chk("mr.dok_rst", 32'(data_ok), 32'd0);
        chk("mr.out_rst", 32'(outstanding), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        xfer("mr.lw0", 1'b0, 2'b10, 32'h0, 32'h0, wv[0]);
        xfer("mr.lw4", 1'b0, 2'b10, 32'h4, 32'h0, wv[1]);

        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req1 = l1_req[c]; wr1 = l1_wr[c]; size1 = 2'b10; addr1 = l1_addr[c]; wdata1 = l1_wd[c];
            #1;
            chk($sformatf("l1.aok%0d", c), 32'(addr_ok1), 32'(l1_aok[c]));
            chk($sformatf("l1.dok%0d", c), 32'(data_ok1), 32'(l1_dok[c]));
            chk($sformatf("l1.out%0d", c), 32'(outstanding1), 32'(l1_out[c]));
            chk($sformatf("l1.rd%0d", c), rdata1, l1_rd[c]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
